register_file_scoreboard: RTL and testbench

Architectural register file for the MIPS datapath: 32 general-purpose registers of 32 bits, two combinational read ports, one synchronous write port, plus a per-register pending-write scoreboard. Sits downstream of the 5-to-32 write-address decode in the memory_elements group. The one-hot write enables gate per-register storage. Consumed by decode/issue for operands and hazard stall, and written by the writeback stage.

---
 rtl/register_file_scoreboard.sv | 105 ++++++++++
 tb/tb_register_file_scoreboard.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
// MIPS architectural register file (r0 hardwired to zero) with two combinational
// read ports, write-through bypass and a per-register pending-write scoreboard.

module register_file_scoreboard_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  iss_sel,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy
);
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (wr_sel) begin
            data_d = wr_data;
            busy_d = 1'b0;
        end
        // A new producer supersedes a writeback from the previous one.
        if (iss_sel) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;
endmodule

module register_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            read_address_a,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic                  busy_a,
    input  logic [4:0]            read_address_b,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  busy_b,
    input  logic                  write_enable,
    input  logic [4:0]            write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  issue_enable,
    input  logic [4:0]            issue_address,
    output logic [NUM_REGS-1:0]   busy_vector
);
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_data;
    logic                                wr_fire;
    logic                                hit_a, hit_b;

    // Gated by reset so the bypass cannot leak write_data while reset is held.
    assign wr_fire = write_enable & rst_n;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign reg_data[i]    = '0;
            assign busy_vector[i] = 1'b0;
        end else begin : g_cell
            logic wr_sel, iss_sel;
            assign wr_sel  = wr_fire && (write_address == 5'(i));
            assign iss_sel = issue_enable && (issue_address == 5'(i));

            register_file_scoreboard_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_sel  (wr_sel),
                .wr_data (write_data),
                .iss_sel (iss_sel),
                .data    (reg_data[i]),
                .busy    (busy_vector[i])
            );
        end
    end

    assign hit_a = wr_fire && (write_address == read_address_a);
    assign hit_b = wr_fire && (write_address == read_address_b);

    always_comb begin
        read_data_a = reg_data[read_address_a];
        read_data_b = reg_data[read_address_b];
        if (read_address_a == 5'd0) read_data_a = '0;
        else if (hit_a)             read_data_a = write_data;
        if (read_address_b == 5'd0) read_data_b = '0;
        else if (hit_b)             read_data_b = write_data;
        busy_a = busy_vector[read_address_a] && !hit_a;
        busy_b = busy_vector[read_address_b] && !hit_b;
    end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench for register_file_scoreboard: directed scenarios then random traffic
// against an array-based reference model.

module tb_register_file_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  read_address_a, read_address_b, write_address, issue_address;
    logic [31:0] read_data_a, read_data_b, write_data;
    logic        busy_a, busy_b, write_enable, issue_enable;
    logic [31:0] busy_vector;

    register_file_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .read_address_a(read_address_a), .read_data_a(read_data_a), .busy_a(busy_a),
        .read_address_b(read_address_b), .read_data_b(read_data_b), .busy_b(busy_b),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .issue_enable(issue_enable), .issue_address(issue_address),
        .busy_vector(busy_vector)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rda, rdb, bvec;
        logic        ba, bb;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk({e.name, ".rda"},  read_data_a, e.rda);
            chk({e.name, ".rdb"},  read_data_b, e.rdb);
            chk({e.name, ".ba"},   32'(busy_a), 32'(e.ba));
            chk({e.name, ".bb"},   32'(busy_b), 32'(e.bb));
            chk({e.name, ".bvec"}, busy_vector, e.bvec);
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] ra, input logic rn, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (!rn || ra == 0) return 32'h0;
        if (we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] ra, input logic rn, input logic we,
                                     input logic [4:0] wa);
        if (!rn) return 1'b0;
        return m_busy[ra] && !(we && wa == ra);
    endfunction

    task automatic drive(input string nm, input logic rn, input logic [4:0] ra, input logic [4:0] rb,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia);
        exp_t e;
        rst_n = rn; read_address_a = ra; read_address_b = rb;
        write_enable = we; write_address = wa; write_data = wd;
        issue_enable = ie; issue_address = ia;
        if (!rn) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
        end
        e.name = nm;
        e.rda  = m_read(ra, rn, we, wa, wd);
        e.rdb  = m_read(rb, rn, we, wa, wd);
        e.ba   = m_rbusy(ra, rn, we, wa);
        e.bb   = m_rbusy(rb, rn, we, wa);
        e.bvec = 0;
        for (int i = 0; i < 32; i++) e.bvec[i] = m_busy[i];
        expq.push_back(e);
        @(posedge clk);
        if (rn) begin
            if (we && wa != 0) begin m_regs[wa] = wd; m_busy[wa] = 1'b0; end
            if (ie && ia != 0) m_busy[ia] = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; read_address_a = 0; read_address_b = 0;
        write_enable = 0; write_address = 0; write_data = 0;
        issue_enable = 0; issue_address = 0;
        @(posedge clk); #1;

        drive("rst_init", 0, 5, 6, 0, 0, 0, 0, 0);
        drive("wr_r5",    1, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        drive("rd_r5",    1, 5, 6, 0, 0, 0, 1, 8);
        drive("rst_mid",  0, 5, 8, 1, 6, 32'h1234, 1, 7);
        drive("rst_hold", 0, 6, 7, 0, 0, 0, 0, 0);
        drive("post_rst", 1, 5, 6, 0, 0, 0, 0, 0);
        drive("post_rst2",1, 7, 8, 0, 0, 0, 0, 0);

        drive("wr_r7",    1, 1, 2, 1, 7, 32'h12345678, 0, 0);
        drive("rd_r7_r0", 1, 7, 0, 0, 0, 0, 0, 0);
        drive("wr_r0",    1, 0, 7, 1, 0, 32'hFFFFFFFF, 0, 0);
        drive("rd_r0",    1, 0, 0, 0, 0, 0, 0, 0);

        drive("wr_r9_old",1, 0, 0, 1, 9, 32'h1, 0, 0);
        drive("byp_r9",   1, 9, 7, 1, 9, 32'hCAFEF00D, 0, 0);
        drive("st_r9",    1, 9, 9, 0, 0, 0, 0, 0);

        drive("iss_r3",   1, 3, 0, 0, 0, 0, 1, 3);
        drive("busy_r3",  1, 3, 4, 0, 0, 0, 0, 0);
        drive("wb_r3",    1, 3, 3, 1, 3, 32'h55, 0, 0);
        drive("free_r3",  1, 3, 0, 0, 0, 0, 0, 0);

        drive("iss_r4",   1, 4, 0, 0, 0, 0, 1, 4);
        drive("iss_wb_r4",1, 4, 0, 1, 4, 32'hAA, 1, 4);
        drive("chk_r4",   1, 4, 4, 0, 0, 0, 1, 0);
        drive("iss_r0",   1, 0, 4, 0, 0, 0, 0, 0);

        drive("wr_r12",   1, 0, 0, 1, 12, 32'h0F0F0F0F, 0, 0);
        drive("dual_r12", 1, 12, 12, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra, rb, wa, ia;
            ra = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            drive("rand", ($urandom_range(0, 99) != 0), ra, rb,
                  ($urandom_range(0, 1) != 0), wa, $urandom,
                  ($urandom_range(0, 2) == 0), ia);
        end
        drive("tail", 1, 0, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 20 && expq.size() > 0; t++) @(posedge clk);
        if (expq.size() > 0) begin
            n_chk++; n_err++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        if (n_chk == 0) begin
            n_chk++; n_err++;
            $display("FAIL no_checks: got 0 checks, expected >0");
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
